fractal_sync_tx_mc: RTL

Parametrised multi-channel successor of the fractal sync tx datapath. Accepts one synchronisation response per cycle and multicasts it into NUM_CH per-channel response FIFOs, selected by a one-hot/multi-hot mask in the low bits of dst. Strips the mask bits from dst and presents each FIFO on a valid/ready output port. Adds a sticky, clearable overflow status and a fill-level output per channel. Sits between a fractal sync tree node and its NUM_CH children.

---
 rtl/fractal_sync_tx_mc.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fractal_sync_tx_mc.sv
// fractal_sync_tx_mc: multicasts one sync response per cycle into NUM_CH registered-head FIFOs; wake-to-valid 1 (COMB_IN=1) or 2 cycles.
// A full channel without a same-cycle pop drops the entry and flags overflow; define FRACTAL_SYNC_TX_MC_OVF_CNT_EN for per-channel drop counters.
module fractal_sync_tx_mc #(
  parameter int NUM_CH     = 2,
  parameter int DST_W      = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int COMB_IN    = 0,
  localparam int ODST_W    = DST_W - NUM_CH,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       rsp_wake_i,
  input  logic [DST_W-1:0]           rsp_dst_i,
  input  logic                       rsp_error_i,
  output logic [NUM_CH-1:0]          rsp_valid_o,
  input  logic [NUM_CH-1:0]          rsp_ready_i,
  output logic [NUM_CH*ODST_W-1:0]   rsp_dst_o,
  output logic [NUM_CH-1:0]          rsp_error_o,
  output logic [NUM_CH*CNT_W-1:0]    fill_o,
  output logic [NUM_CH-1:0]          overflow_o,
  input  logic [NUM_CH-1:0]          overflow_clr_i,
  output logic [NUM_CH*8-1:0]        ovf_cnt_o,
  output logic                       unroutable_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  if (NUM_CH < 2) begin : g_err_num_ch
    $fatal(1, "fractal_sync_tx_mc: NUM_CH must be >= 2");
  end
  if (FIFO_DEPTH < 1) begin : g_err_depth
    $fatal(1, "fractal_sync_tx_mc: FIFO_DEPTH must be >= 1");
  end
  if (DST_W <= NUM_CH) begin : g_err_dst_w
    $fatal(1, "fractal_sync_tx_mc: DST_W must exceed NUM_CH");
  end

  // Explicit wrap so non-power-of-2 depths index only valid entries
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic             wake_s;
  logic [DST_W-1:0] dst_s;
  logic             error_s;

  if (COMB_IN != 0) begin : g_comb_in
    assign wake_s  = rsp_wake_i;
    assign dst_s   = rsp_dst_i;
    assign error_s = rsp_error_i;
  end else begin : g_reg_in
    logic             wake_q;
    logic [DST_W-1:0] dst_q;
    logic             error_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wake_q  <= 1'b0;
        dst_q   <= '0;
        error_q <= 1'b0;
      end else begin
        wake_q  <= rsp_wake_i;
        dst_q   <= rsp_dst_i;
        error_q <= rsp_error_i;
      end
    end

    assign wake_s  = wake_q;
    assign dst_s   = dst_q;
    assign error_s = error_q;
  end

  logic [ODST_W-1:0] push_dst;
  logic [NUM_CH-1:0] drop;

  assign push_dst = dst_s[DST_W-1:NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ODST_W-1:0] mem_dst [FIFO_DEPTH];
    logic              mem_err [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              push;
    logic              pop;
    logic              full;
    logic              wr_en;
    logic              ovf_q;

    assign push  = wake_s & dst_s[i];
    assign pop   = (cnt != '0) & rsp_ready_i[i];
    assign full  = (cnt == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full channel still accepts
    assign wr_en = push & (~full | pop);
    assign drop[i] = push & full & ~pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < FIFO_DEPTH; k++) begin
          mem_dst[k] <= '0;
          mem_err[k] <= 1'b0;
        end
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (wr_en) begin
          mem_dst[wr_ptr] <= push_dst;
          mem_err[wr_ptr] <= error_s;
          wr_ptr          <= ptr_inc(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        if (wr_en && !pop) begin
          cnt <= cnt + CNT_W'(1);
        end else if (pop && !wr_en) begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end

    // Set has priority over clear so no overflow event is lost
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ovf_q <= 1'b0;
      end else if (drop[i]) begin
        ovf_q <= 1'b1;
      end else if (overflow_clr_i[i]) begin
        ovf_q <= 1'b0;
      end
    end

    assign rsp_valid_o[i]                  = (cnt != '0);
    assign rsp_dst_o[i*ODST_W +: ODST_W]   = mem_dst[rd_ptr];
    assign rsp_error_o[i]                  = mem_err[rd_ptr];
    assign fill_o[i*CNT_W +: CNT_W]        = cnt;
    assign overflow_o[i]                   = ovf_q;
  end

`ifdef FRACTAL_SYNC_TX_MC_OVF_CNT_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ovf_cnt
    logic [7:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (overflow_clr_i[i]) begin
        cnt_q <= drop[i] ? 8'd1 : 8'd0;
      end else if (drop[i] && (cnt_q != 8'hFF)) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end

    assign ovf_cnt_o[i*8 +: 8] = cnt_q;
  end
`else
  assign ovf_cnt_o = '0;
`endif

  logic unroutable_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      unroutable_q <= 1'b0;
    end else if (wake_s && (dst_s[NUM_CH-1:0] == '0)) begin
      unroutable_q <= 1'b1;
    end
  end

  assign unroutable_o = unroutable_q;

endmodule
